// File: rtl/mem_stage_nb.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_nb
// Brief    : Non-blocking memory-access stage between EX and WB. Holds up to
//            DEPTH in-order instructions, matches data responses to waiting
//            entries in order, aligns/extends load data, retires in order and
//            discards responses orphaned by a WB exception or ERTN flush.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_nb #(
    parameter int DEPTH  = 2,
    parameter int SIDE_W = 184,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_mem_valid,
    input  logic [SIDE_W+44:0]   ex_mem_bus,
    output logic                 mem_allowin,
    output logic                 mem_wb_valid,
    input  logic                 wb_allowin,
    output logic [SIDE_W+40:0]   mem_wb_bus,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 wb_ex,
    input  logic                 ertn_flush,
    output logic                 mem_ex,
    output logic                 mem_ertn,
    output logic                 fwd_valid,
    output logic [4:0]           fwd_dest,
    output logic [31:0]          fwd_data,
    output logic [DEPTH*6-1:0]   dest_vec,
    output logic [CNT_W-1:0]     occupancy
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_IN_W  = SIDE_W + 45;
    // The named inbound fields take 46 bits, so the opaque payload is the
    // SIDE_W-1 bits below alu_result. Outbound, it sits in the low bits of the
    // side field with two zero bits above it.
    localparam int c_PAY_W    = SIDE_W - 1;
    localparam int c_ALU_LSB  = SIDE_W - 1;
    localparam int c_AL_LSB   = SIDE_W + 31;
    localparam int c_MT_LSB   = SIDE_W + 33;
    localparam int c_RFM      = SIDE_W + 36;
    localparam int c_DEST_LSB = SIDE_W + 37;
    localparam int c_GWE      = SIDE_W + 42;
    localparam int c_ERTN     = SIDE_W + 43;
    localparam int c_EXF      = SIDE_W + 44;
    localparam logic [CNT_W:0] c_DEPTH_X = (CNT_W + 1)'(DEPTH);

    // Entry storage
    logic [c_IN_W-1:0]   r_bus  [DEPTH];
    logic [31:0]         r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_got;
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]    r_occ;
    logic [CNT_W-1:0]    r_disc;

    logic [DEPTH-1:0]    w_waiting;
    logic [DEPTH-1:0]    w_exf_vec;
    logic [DEPTH-1:0]    w_ertn_vec;
    logic                w_flush;
    logic                w_tgt_found;
    logic [c_PTR_W-1:0]  w_tgt_idx;
    logic [CNT_W-1:0]    w_wait_cnt;
    logic                w_route_fill;
    logic                w_drop;
    logic [c_IN_W-1:0]   w_head_bus;
    logic                w_head_valid;
    logic                w_head_ready;
    logic [2:0]          w_head_mt;
    logic [1:0]          w_head_al;
    logic [31:0]         w_rd;
    logic [15:0]         w_half;
    logic [7:0]          w_byte;
    logic [31:0]         w_ext;
    logic [31:0]         w_final;
    logic                w_retire;
    logic                w_accept;
    logic [CNT_W:0]      w_load;
    logic [CNT_W-1:0]    w_occ_next;
    logic                w_disc_dec;
    logic [CNT_W-1:0]    w_disc_flush;

    // Per-slot status decode and hazard vector
    for (genvar j = 0; j < DEPTH; j++) begin : g_slot
        logic w_mem_op;
        assign w_mem_op      = |r_bus[j][c_MT_LSB +: 3];
        assign w_waiting[j]  = r_valid[j] & w_mem_op & ~r_got[j];
        assign w_exf_vec[j]  = r_valid[j] & r_bus[j][c_EXF];
        assign w_ertn_vec[j] = r_valid[j] & r_bus[j][c_ERTN];
        assign dest_vec[6*j +: 6] = {r_valid[j] & r_bus[j][c_GWE],
                                     r_bus[j][c_DEST_LSB +: 5]};
    end

    assign w_flush = wb_ex | ertn_flush;

    // Find the oldest entry still waiting for its response (scan from head)
    always_comb begin
        w_tgt_found = 1'b0;
        w_tgt_idx   = r_head;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_waiting[r_head + c_PTR_W'(i)]) begin
                w_tgt_found = 1'b1;
                w_tgt_idx   = r_head + c_PTR_W'(i);
            end
        end
    end

    // Count entries still owed a response; these become orphans on flush
    always_comb begin
        w_wait_cnt = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_wait_cnt = w_wait_cnt + CNT_W'(w_waiting[j]);
        end
    end

    // Orphaned responses are absorbed before any live entry sees data
    assign w_drop       = data_sram_data_ok & (r_disc != '0);
    assign w_route_fill = data_sram_data_ok & (r_disc == '0) & w_tgt_found;

    assign w_head_bus   = r_bus[r_head];
    assign w_head_valid = r_valid[r_head];
    assign w_head_mt    = w_head_bus[c_MT_LSB +: 3];
    assign w_head_al    = w_head_bus[c_AL_LSB +: 2];
    assign w_head_ready = (w_head_mt == 3'd0) | r_got[r_head] |
                          (w_route_fill & (w_tgt_idx == r_head));
    // A response arriving for the head this cycle is used without a bubble
    assign w_rd         = r_got[r_head] ? r_data[r_head] : data_sram_rdata;

    // Lane selection and sign/zero extension of load data
    always_comb begin
        w_half = w_head_al[1] ? w_rd[31:16] : w_rd[15:0];
        case (w_head_al)
            2'd0:    w_byte = w_rd[7:0];
            2'd1:    w_byte = w_rd[15:8];
            2'd2:    w_byte = w_rd[23:16];
            default: w_byte = w_rd[31:24];
        endcase
        if (w_head_mt[1:0] == 2'b11) begin
            w_ext = w_rd;
        end else begin
            case (w_head_mt)
                3'b001:  w_ext = {{16{w_half[15]}}, w_half};
                3'b101:  w_ext = {16'd0, w_half};
                3'b010:  w_ext = {{24{w_byte[7]}}, w_byte};
                default: w_ext = {24'd0, w_byte};
            endcase
        end
    end

    assign w_final = w_head_bus[c_RFM] ? w_ext : w_head_bus[c_ALU_LSB +: 32];

    assign mem_wb_valid = w_head_valid & w_head_ready & ~w_flush;
    assign w_retire     = mem_wb_valid & wb_allowin;
    // Orphans still to arrive reserve capacity so outstanding never exceeds DEPTH
    assign w_load       = {1'b0, r_occ} + {1'b0, r_disc};
    assign mem_allowin  = (w_load < c_DEPTH_X) | w_retire;
    assign w_accept     = ex_mem_valid & mem_allowin & ~w_flush;

    assign mem_wb_bus = {w_head_bus[c_EXF], w_head_bus[c_ERTN], w_head_bus[c_GWE],
                         w_head_bus[c_DEST_LSB +: 5], w_final, 2'b00,
                         w_head_bus[c_PAY_W-1:0]};

    assign fwd_valid = w_head_valid & w_head_bus[c_GWE] &
                       (~w_head_bus[c_RFM] | w_head_ready);
    assign fwd_dest  = w_head_bus[c_DEST_LSB +: 5];
    assign fwd_data  = w_final;
    assign mem_ex    = |w_exf_vec;
    assign mem_ertn  = |w_ertn_vec;
    assign occupancy = r_occ;

    // Next occupancy for the non-flush case
    always_comb begin
        w_occ_next = r_occ;
        if (w_accept & ~w_retire) begin
            w_occ_next = r_occ + CNT_W'(1);
        end else if (w_retire & ~w_accept) begin
            w_occ_next = r_occ - CNT_W'(1);
        end
    end

    // On flush, waiting entries turn into orphans; a same-cycle response is
    // charged to whichever of them (or earlier orphans) it belongs to.
    assign w_disc_dec   = data_sram_data_ok & ((r_disc != '0) | (w_wait_cnt != '0));
    assign w_disc_flush = r_disc + w_wait_cnt - CNT_W'(w_disc_dec);

    // Queue control: pointers, valid/got flags, occupancy and discard count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_got   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_disc  <= '0;
        end else if (w_flush) begin
            r_valid <= '0;
            r_got   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_disc  <= w_disc_flush;
        end else begin
            if (w_drop) begin
                r_disc <= r_disc - CNT_W'(1);
            end
            if (w_route_fill) begin
                r_got[w_tgt_idx] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            // Accept last: with a full queue the tail slot is the retiring head
            if (w_accept) begin
                r_valid[r_tail] <= 1'b1;
                r_got[r_tail]   <= 1'b0;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            r_occ <= w_occ_next;
        end
    end

    // Entry payload and captured response data
    always_ff @(posedge clk) begin
        if (w_route_fill & ~w_flush) begin
            r_data[w_tgt_idx] <= data_sram_rdata;
        end
        if (w_accept) begin
            r_bus[r_tail] <= ex_mem_bus;
        end
    end

endmodule
`default_nettype wire
